imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator for the decode stage. Accepts one
//  instruction per cycle over valid/ready and decodes all RV32I immediate formats
//  (I/S/B/U/J), sign-extended to XLEN. Selects operand B (immediate or rs2 data)
//  and registers the result through a 2-entry skid buffer, giving full-throughput
//  backpressure between decode and execute. Supports a synchronous pipeline flush.
// PARAMETERS
//  XLEN   32  datapath width; 32 or 64 only; immediates sign-extend from bit 31 of instr
//  TAG_W  5   width of opaque sideband tag (e.g. rd index / ROB id) carried with data
// PORTS
//  clk            in   1       clock, rising edge
//  rst_n          in   1       asynchronous active-low reset
//  flush          in   1       sync flush: discard all held entries
//  in_valid       in   1       input instruction valid
//  in_ready       out  1       block can accept input this cycle
//  in_instr       in   32      raw instruction word
//  in_rs2_data    in   XLEN    rs2 register-file read data
//  in_alu_src     in   1       1: operand B = immediate; 0: operand B = rs2 data
//  in_tag         in   TAG_W   sideband, passed through unchanged
//  out_valid      out  1       output entry valid
//  out_ready      in   1       consumer accepts output this cycle
//  out_imm        out  XLEN    decoded, sign-extended immediate
//  out_operand_b  out  XLEN    in_alu_src ? imm : rs2 data
//  out_fmt        out  3       0=R 1=I 2=S 3=B 4=U 5=J (6,7 reserved)
//  out_tag        out  TAG_W   tag of the output entry
// BEHAVIOUR
//  - Decode by opcode instr[6:0]: I = 0010011,0000011,1100111,1110011; S = 0100011;
//    B = 1100011; U = 0110111,0010111; J = 1101111; R = 0110011 (imm=0).
//  - I: sext(i[31:20]); S: sext({i[31:25],i[11:7]}); B: sext({i[31],i[7],i[30:25],
//    i[11:8],1'b0}); U: sext({i[31:12],12'b0}); J: sext({i[31],i[19:12],i[20],
//    i[30:21],1'b0}). sext replicates i[31] to XLEN (U also sign-extends for XLEN=64).
//  - Unknown opcode: imm=0, fmt=R, operand_b per in_alu_src (imm 0 if set).
//  - Accept when in_valid && in_ready. Latency 1: accepted data visible on out_* at
//    the next edge. Throughput 1/cycle while out_ready high.
//  - Skid buffer: main + skid register. in_ready = !skid_valid (registered, no comb
//    path from out_ready). Output sourced from main; skid refills main on out fire.
//  - Strict FIFO order; no entry dropped or duplicated under any ready pattern.
//  - Empty: out_valid=0, outputs hold last value (don't-care). Full (2 held):
//    in_ready=0; simultaneous out fire + no input -> 1 held, in_ready=1 next cycle.
//  - Simultaneous out fire and in fire with 1 held: main takes new data, count stays 1.
//  - flush: at next edge both entries invalid, in_valid that cycle ignored (flush wins).
//  - Reset (async, any time incl. mid-transfer): out_valid=0, in_ready=1,
//    out_imm=0, out_operand_b=0, out_fmt=0, out_tag=0, skid cleared.
// CONFIGURATION
//  IMM_ILLEGAL_DET_EN defined: adds port out_illegal (out,1), registered with the
//    entry; 1 when opcode not in the decode table or instr[1:0]!=2'b11; reset 0.
//    Illegal entries still flow through with imm=0, fmt=R.
//  Undefined: no out_illegal port; unknown opcodes decode silently as R, imm=0.
// TESTING
//  1 addi 0xFFF00093, alu_src=1 -> next cycle out_imm=out_operand_b=0xFFFFFFFF, fmt=1.
//  2 sw 0xFE112E23 -> imm 0xFFFFFFFC fmt=2; lui 0x123450B7 -> 0x12345000 fmt=4;
//    jal 0x0010006F -> 0x00000800 fmt=5; XLEN=64 repeat: upper 32 bits sign-match.
//  3 back-to-back stream of 8 instrs, out_ready=1 -> 8 outputs on 8 consecutive
//    cycles, tags 0..7 in order, in_ready never low.
//  4 out_ready=0 for 3 cycles with in_valid=1 -> in_ready low after 2 accepts; on
//    release tags emerge 0,1,2 in order, nothing lost.
//  5 flush with 2 entries held and in_valid=1 -> next cycle out_valid=0, in_ready=1;
//    flushed tag never appears. rst_n pulsed low mid-stream -> all outputs 0 at once.
//  6 opcode 0x7F with IMM_ILLEGAL_DET_EN -> out_illegal=1, imm=0, fmt=0; without
//    the macro -> imm=0, fmt=0, alu_src=0 gives operand_b=rs2 data.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I immediate generator with operand-B select and a 2-entry skid buffer.
// Optional IMM_ILLEGAL_DET_EN adds out_illegal for unknown opcodes.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic             in_alu_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_operand_b,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_DET_EN
  , output logic           out_illegal
`endif
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  opb;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } ent_t;
  ent_t main_e, skid_e, new_e;
  logic main_valid, skid_valid;
  logic [6:0] opc;
  logic is_r, is_i, is_s, is_b, is_u, is_j;
  logic [31:0] imm32;
  logic in_fire, out_fire;
  assign opc  = in_instr[6:0];
  assign is_i = opc == 7'h13 || opc == 7'h03 || opc == 7'h67 || opc == 7'h73;
  assign is_s = opc == 7'h23;
  assign is_b = opc == 7'h63;
  assign is_u = opc == 7'h37 || opc == 7'h17;
  assign is_j = opc == 7'h6f;
  assign is_r = opc == 7'h33;
  always_comb begin
    imm32 = is_i ? {{20{in_instr[31]}}, in_instr[31:20]} :
            is_s ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
            is_b ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
            is_u ? {in_instr[31:12], 12'b0} :
            is_j ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
            32'b0;
    new_e.imm = XLEN'($signed(imm32));
    new_e.opb = in_alu_src ? new_e.imm : in_rs2_data;
    new_e.fmt = is_i ? 3'd1 : is_s ? 3'd2 : is_b ? 3'd3 : is_u ? 3'd4 : is_j ? 3'd5 : 3'd0;
    new_e.tag = in_tag;
  end
  assign in_fire  = in_valid && in_ready && !flush;
  assign out_fire = main_valid && out_ready;
  // Main always feeds the output; skid only fills while main is stalled, so in_ready is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_e     <= '0;
      skid_e     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      if (skid_valid) begin
        main_e     <= skid_e;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_fire;
        if (in_fire) main_e <= new_e;
      end
    end else if (in_fire) begin
      skid_e     <= new_e;
      skid_valid <= 1'b1;
    end
  end
`ifdef IMM_ILLEGAL_DET_EN
  logic new_ill, main_ill, skid_ill;
  assign new_ill = !(is_r || is_i || is_s || is_b || is_u || is_j) || in_instr[1:0] != 2'b11;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ill <= 1'b0;
      skid_ill <= 1'b0;
    end else if (!flush && (!main_valid || out_fire)) begin
      if (skid_valid) main_ill <= skid_ill;
      else if (in_fire) main_ill <= new_ill;
    end else if (!flush && in_fire) begin
      skid_ill <= new_ill;
    end
  end
  assign out_illegal = main_ill;
`endif
  assign in_ready      = !skid_valid;
  assign out_valid     = main_valid;
  assign out_imm       = main_e.imm;
  assign out_operand_b = main_e.opb;
  assign out_fmt       = main_e.fmt;
  assign out_tag       = main_e.tag;
endmodule
